// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one main-memory block port between the instruction cache and the
// data cache. Each cache issues whole-block refills (reads) or write-backs
// (writes); the arbiter serialises them onto the memory port. It returns the
// refill block to the winning cache and releases that side's busywait for
// exactly one cycle.
//
// Parameters
//   ADDR_W  - block-address width (byte address bits [31:4])
//   BLOCK_W - block width in bits
//
// Ports
//   CLK, RESET          - clock, synchronous active-high reset
//   I_READ, I_ADDRESS   - I-cache refill request and block address
//   I_READDATA          - refill block returned to the I-cache
//   I_BUSYWAIT          - I-side stall
//   D_READ, D_WRITE     - D-cache refill / write-back request
//   D_ADDRESS           - D-side block address
//   D_WRITEDATA         - write-back block
//   D_READDATA          - refill block returned to the D-cache
//   D_BUSYWAIT          - D-side stall
//   M_READ, M_WRITE     - memory read / write strobes
//   M_ADDRESS           - memory block address
//   M_WRITEDATA         - memory write block
//   M_READDATA          - memory read block, valid when M_BUSYWAIT falls
//   M_BUSYWAIT          - memory busy
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,

    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,

    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,

    output logic               M_READ,
    output logic               M_WRITE,
    output logic [ADDR_W-1:0]  M_ADDRESS,
    output logic [BLOCK_W-1:0] M_WRITEDATA,
    input  logic [BLOCK_W-1:0] M_READDATA,
    input  logic               M_BUSYWAIT
);

    typedef enum logic [2:0] {
        StIdle,
        StIReq,
        StIWait,
        StIDone,
        StDReq,
        StDWait,
        StDDone
    } state_e;

    state_e state_q;

    // Tie-break priority: set means the D side wins the next tie. It is the
    // complement of "D was granted last"; out of reset D has priority, and
    // every grant hands priority to the other side so ties alternate.
    logic d_first_q;

    logic d_req;
    logic grant_i;
    logic grant_d;

    always_comb begin
        d_req   = D_READ | D_WRITE;
        grant_d = d_req & (~I_READ | d_first_q);
        grant_i = I_READ & ~grant_d;
    end

    // Combinational stall: only the DONE state of a side releases it.
    assign I_BUSYWAIT = I_READ & (state_q != StIDone);
    assign D_BUSYWAIT = d_req & (state_q != StDDone);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            d_first_q   <= 1'b1;
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
            I_READDATA  <= '0;
            D_READDATA  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        state_q     <= StDReq;
                        d_first_q   <= 1'b0;
                        // Read and write together is treated as a write-back.
                        M_READ      <= ~D_WRITE;
                        M_WRITE     <= D_WRITE;
                        M_ADDRESS   <= D_ADDRESS;
                        M_WRITEDATA <= D_WRITEDATA;
                    end else if (grant_i) begin
                        state_q   <= StIReq;
                        d_first_q <= 1'b1;
                        M_READ    <= 1'b1;
                        M_WRITE   <= 1'b0;
                        M_ADDRESS <= I_ADDRESS;
                    end
                end

                // Memory may not have registered the strobe yet, so its
                // busywait is not meaningful in the request cycle.
                StIReq: state_q <= StIWait;
                StDReq: state_q <= StDWait;

                StIWait: begin
                    if (!M_BUSYWAIT) begin
                        I_READDATA <= M_READDATA;
                        M_READ     <= 1'b0;
                        state_q    <= StIDone;
                    end
                end

                StDWait: begin
                    if (!M_BUSYWAIT) begin
                        if (M_READ) begin
                            D_READDATA <= M_READDATA;
                        end
                        M_READ  <= 1'b0;
                        M_WRITE <= 1'b0;
                        state_q <= StDDone;
                    end
                end

                // One release cycle; arbitration resumes in the next IDLE.
                StIDone: state_q <= StIdle;
                StDDone: state_q <= StIdle;

                default: begin
                    state_q <= StIdle;
                    M_READ  <= 1'b0;
                    M_WRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized two-requester run checked through per-side scoreboards.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          I_READ = 1'b0;
    logic [AW-1:0] I_ADDRESS = '0;
    logic [BW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ = 1'b0;
    logic          D_WRITE = 1'b0;
    logic [AW-1:0] D_ADDRESS = '0;
    logic [BW-1:0] D_WRITEDATA = '0;
    logic [BW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          M_READ;
    logic          M_WRITE;
    logic [AW-1:0] M_ADDRESS;
    logic [BW-1:0] M_WRITEDATA;
    logic [BW-1:0] M_READDATA = '0;
    logic          M_BUSYWAIT;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA),
        .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS),
        .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: no response within cycle bound", name);
    endtask

    // Memory contents: fixed per-address pattern, with the A5 block at 0x10.
    function automatic logic [BW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {4{32'hA5A5A5A5}};
        return {4'h1, a, 4'h2, ~a, 4'h3, a ^ 28'h5A5A5A5, 4'h4, a + 28'd1};
    endfunction

    // ---------------- memory model ----------------
    // On the first edge that sees a strobe it starts, then holds busywait for
    // the chosen latency; the edge after that sees busywait low.
    int unsigned   lat_cfg  = 0;
    bit            lat_rand = 0;
    logic          m_act    = 1'b0;
    int unsigned   m_cnt    = 0;
    int            m_starts = 0;
    logic          rec_rd   = 1'b0;
    logic          rec_wr   = 1'b0;
    logic [AW-1:0] rec_addr = '0;
    logic [BW-1:0] rec_wdata = '0;

    assign M_BUSYWAIT = m_act && (m_cnt != 0);

    always @(posedge CLK) begin
        M_READDATA <= pattern(M_ADDRESS);
        if (RESET) begin
            m_act <= 1'b0;
            m_cnt <= 0;
        end else if (!m_act) begin
            if (M_READ || M_WRITE) begin
                m_act     <= 1'b1;
                m_cnt     <= lat_rand ? $urandom_range(0, 5) : lat_cfg;
                m_starts  <= m_starts + 1;
                rec_rd    <= M_READ;
                rec_wr    <= M_WRITE;
                rec_addr  <= M_ADDRESS;
                rec_wdata <= M_WRITEDATA;
            end
        end else if (!(M_READ || M_WRITE)) begin
            m_act <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
    } exp_t;

    exp_t          q_i[$];
    exp_t          q_d[$];
    bit            mon_en = 0;
    logic [BW-1:0] exp_d_rd = '0;
    int            i_skip = 0;
    int            d_skip = 0;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (I_READ && !I_BUSYWAIT) begin
                if (q_i.size() == 0) bound_fail("i_unexpected_release");
                else begin
                    exp_t e;
                    e = q_i.pop_front();
                    check("i_mem_op", BW'({rec_rd, rec_wr}), BW'(2'b10));
                    check("i_mem_addr", BW'(rec_addr), BW'(e.addr));
                    check("i_readdata", I_READDATA, e.rdata);
                    check("i_starvation", BW'(i_skip <= 1), BW'(1));
                end
                i_skip = 0;
                if (D_READ || D_WRITE) d_skip++;
            end
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                if (q_d.size() == 0) bound_fail("d_unexpected_release");
                else begin
                    exp_t e;
                    e = q_d.pop_front();
                    check("d_mem_op", BW'({rec_rd, rec_wr}), BW'({~e.wr, e.wr}));
                    check("d_mem_addr", BW'(rec_addr), BW'(e.addr));
                    if (e.wr) begin
                        check("d_mem_wdata", rec_wdata, e.wdata);
                        check("d_readdata_hold", D_READDATA, exp_d_rd);
                    end else begin
                        check("d_readdata", D_READDATA, e.rdata);
                        exp_d_rd = e.rdata;
                    end
                    check("d_starvation", BW'(d_skip <= 1), BW'(1));
                end
                d_skip = 0;
                if (I_READ) i_skip++;
            end
        end
    end

    // ---------------- random drivers ----------------
    task automatic drv_i(input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a;
            bit            done;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            a = {1'b0, 27'($urandom)};
            q_i.push_back('{wr: 1'b0, addr: a, wdata: '0, rdata: pattern(a)});
            #1;
            I_ADDRESS = a;
            I_READ    = 1'b1;
            done = 0;
            for (int c = 0; c < 300 && !done; c++) begin
                @(negedge CLK);
                done = !I_BUSYWAIT;
            end
            if (!done) bound_fail("i_random_release");
            #1 I_READ = 1'b0;
        end
    endtask

    task automatic drv_d(input int n);
        for (int k = 0; k < n; k++) begin
            int unsigned   r;
            logic [AW-1:0] a;
            logic [BW-1:0] wd;
            bit            done;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            r  = $urandom_range(0, 2);   // 0 read, 1 write, 2 read+write
            wd = {$urandom, $urandom, $urandom, $urandom};
            a  = {(r != 0), 27'($urandom)};
            q_d.push_back('{wr: (r != 0), addr: a, wdata: wd, rdata: pattern(a)});
            #1;
            D_ADDRESS   = a;
            D_WRITEDATA = wd;
            D_READ      = (r != 1);
            D_WRITE     = (r != 0);
            done = 0;
            for (int c = 0; c < 300 && !done; c++) begin
                @(negedge CLK);
                done = !D_BUSYWAIT;
            end
            if (!done) bound_fail("d_random_release");
            #1;
            D_READ  = 1'b0;
            D_WRITE = 1'b0;
        end
    endtask

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Issue one request (called at a negedge) and wait for its release.
    task automatic run_txn(input bit side_d, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] wd,
                           input bit hold_extra, output int rd_cyc, output int wr_cyc);
        bit done;
        rd_cyc = 0;
        wr_cyc = 0;
        done   = 0;
        if (side_d) begin
            D_READ = rd; D_WRITE = wr; D_ADDRESS = a; D_WRITEDATA = wd;
        end else begin
            I_READ = 1'b1; I_ADDRESS = a;
        end
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge CLK);
            if (M_READ) rd_cyc++;
            if (M_WRITE) wr_cyc++;
            done = side_d ? !D_BUSYWAIT : !I_BUSYWAIT;
        end
        if (!done) bound_fail("directed_release");
        if (hold_extra) begin
            @(negedge CLK);
            check("release_one_cycle", BW'(side_d ? D_BUSYWAIT : I_BUSYWAIT), BW'(1));
        end
        I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, wc, cyc, bad, base;
        bit done;
        int order[$];

        do_reset();
        check("rst_m_read", BW'(M_READ), BW'(0));
        check("rst_m_write", BW'(M_WRITE), BW'(0));
        check("rst_m_address", BW'(M_ADDRESS), BW'(0));
        check("rst_m_writedata", M_WRITEDATA, '0);
        check("rst_i_readdata", I_READDATA, '0);
        check("rst_d_readdata", D_READDATA, '0);
        check("rst_busywait", BW'({I_BUSYWAIT, D_BUSYWAIT}), BW'(0));

        // I refill alone, L=4
        lat_cfg = 4;
        run_txn(0, 1, 0, 28'h0000010, '0, 1, rc, wc);
        check("i_alone_read_cycles", BW'(rc), BW'(6));
        check("i_alone_no_write", BW'(wc), BW'(0));
        check("i_alone_addr", BW'(rec_addr), BW'(28'h10));
        check("i_alone_data", I_READDATA, {4{32'hA5A5A5A5}});
        check("i_alone_idle_strobe", BW'({M_READ, M_WRITE}), BW'(0));

        // D write-back alone, L=2
        lat_cfg = 2;
        run_txn(1, 0, 1, 28'h0000020, 128'h123456789ABCDEF0_0FEDCBA987654321, 0, rc, wc);
        check("d_wb_write_cycles", BW'(wc), BW'(4));
        check("d_wb_no_read", BW'(rc), BW'(0));
        check("d_wb_addr", BW'(rec_addr), BW'(28'h20));
        check("d_wb_wdata", M_WRITEDATA, 128'h123456789ABCDEF0_0FEDCBA987654321);
        check("d_wb_readdata_kept", D_READDATA, '0);

        // Simultaneous requests after reset: D, I, D, I
        do_reset();
        lat_cfg = 1;
        I_ADDRESS = 28'h30; D_ADDRESS = 28'h40; I_READ = 1'b1; D_READ = 1'b1;
        for (int n = 0; n < 200 && order.size() < 4; n++) begin
            @(negedge CLK);
            if (I_READ && !I_BUSYWAIT) begin
                order.push_back(0);
                check("tie_i_data", I_READDATA, pattern(28'h30));
            end
            if (D_READ && !D_BUSYWAIT) begin
                order.push_back(1);
                check("tie_d_data", D_READDATA, pattern(28'h40));
            end
        end
        I_READ = 1'b0; D_READ = 1'b0;
        if (order.size() < 4) bound_fail("tie_sequence");
        else begin
            check("tie_grant0", BW'(order[0]), BW'(1));
            check("tie_grant1", BW'(order[1]), BW'(0));
            check("tie_grant2", BW'(order[2]), BW'(1));
            check("tie_grant3", BW'(order[3]), BW'(0));
        end
        repeat (3) @(negedge CLK);

        // Read and write both high is a write, L=0
        lat_cfg = 0;
        run_txn(1, 1, 1, 28'h0000050, {4{32'hDEADBEEF}}, 0, rc, wc);
        check("rw_write_cycles", BW'(wc), BW'(2));
        check("rw_no_read", BW'(rc), BW'(0));
        check("rw_wdata", rec_wdata, {4{32'hDEADBEEF}});
        check("rw_readdata_kept", D_READDATA, pattern(28'h40));

        // Reset in D_WAIT
        lat_cfg = 8;
        D_ADDRESS = 28'h60; D_READ = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; D_READ = 1'b0;
        check("midrst_strobes", BW'({M_READ, M_WRITE}), BW'(0));
        check("midrst_i_readdata", I_READDATA, '0);
        check("midrst_d_readdata", D_READDATA, '0);
        @(negedge CLK);
        lat_cfg = 2;
        run_txn(0, 1, 0, 28'h0000070, '0, 0, rc, wc);
        check("postrst_i_read_cycles", BW'(rc), BW'(4));
        check("postrst_i_data", I_READDATA, pattern(28'h70));

        // I withdrawn during I_WAIT with D pending
        lat_cfg = 4;
        base = m_starts;
        I_ADDRESS = 28'h80; I_READ = 1'b1;
        @(negedge CLK);
        D_ADDRESS = 28'h90; D_READ = 1'b1;
        @(negedge CLK);
        I_READ = 1'b0;
        cyc = 2; bad = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (I_BUSYWAIT) bad++;
            if (!D_BUSYWAIT) done = 1;
        end
        if (!done) bound_fail("withdraw_d_release");
        check("withdraw_i_busywait_low", BW'(bad), BW'(0));
        check("withdraw_d_done_cycle", BW'(cyc), BW'(15));
        check("withdraw_i_data", I_READDATA, pattern(28'h80));
        check("withdraw_d_data", D_READDATA, pattern(28'h90));
        check("withdraw_mem_txns", BW'(m_starts - base), BW'(2));
        D_READ = 1'b0;
        repeat (2) @(negedge CLK);

        // Randomized contention with scoreboard checking
        do_reset();
        lat_rand = 1;
        exp_d_rd = '0;
        i_skip = 0;
        d_skip = 0;
        mon_en = 1;
        fork
            drv_i(40);
            drv_d(40);
        join
        repeat (5) @(negedge CLK);
        mon_en = 0;
        check("sb_i_drained", BW'(q_i.size()), BW'(0));
        check("sb_d_drained", BW'(q_d.size()), BW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
